spi_device: RTL

SPI peripheral-side endpoint for the team's 8-bit, LSB-first, host-clocked serial link. It oversamples the host's `sclk`, `mosi` and `cs_n` on its own faster system clock and deserialises each received byte into `rx_data`. In the same frame it serialises a double-buffered transmit byte onto `miso`, so the link is full duplex. It sits on the device side of the link, between the pins and local control logic.

---
 rtl/spi_device.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/spi_device.sv
// Device-side endpoint of the 8-bit LSB-first SPI link: oversampled pins,
// full-duplex shift registers, double-buffered TX byte, and idle-timeout abort.
module spi_device #(
  parameter int SYNC_STAGES  = 2,
  parameter int IDLE_TIMEOUT = 64
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       sclk,
  input  logic       mosi,
  input  logic       cs_n,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_empty,
  output logic       tx_underrun,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

  localparam int TW = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                   sclk_d;
  logic                   sclk_s, mosi_s, cs_s;

  logic [6:0]    rx_shift;
  logic [3:0]    rx_cnt;
  logic          rx_done;
  logic [7:0]    tx_shift;
  logic [7:0]    tx_buf;
  logic [3:0]    tx_cnt;
  logic          armed;
  logic [TW-1:0] timer;

  logic active, rise, fall, mid_byte, abort;
  logic rx_last, tx_last, underrun_hit, arm;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];

  // The select synchroniser resets to "deselected" so the link starts in IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '1;
      sclk_d    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its pre-edge value regardless of statement order.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sclk_d    <= sclk_s;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d      = state_q;
    active       = 1'b0;
    rise         = 1'b0;
    fall         = 1'b0;
    abort        = 1'b0;
    mid_byte     = (rx_cnt != 4'd0) || (tx_cnt != 4'd0);
    case (state_q)
      IDLE:   if (!cs_s) state_d = ACTIVE;
      ACTIVE: begin
        active = 1'b1;
        rise   = sclk_s & ~sclk_d;
        fall   = ~sclk_s & sclk_d;
        abort  = mid_byte && (cs_s || timer == TW'(IDLE_TIMEOUT));
        if (cs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rx_last      = rise && rx_cnt == 4'd7;
    tx_last      = fall && tx_cnt == 4'd7;
    underrun_hit = rise && rx_cnt == 4'd0 && !armed;
    arm          = !armed && !tx_empty && !underrun_hit;
  end

  // Receive path; the completing 8th rise takes priority over an abort.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_shift <= '0;
      rx_cnt   <= '0;
      rx_data  <= '0;
      rx_done  <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      rx_done  <= 1'b0;
      rx_valid <= rx_done;
      if (!active) begin
        rx_cnt <= '0;
      end else if (rx_last) begin
        rx_data <= {mosi_s, rx_shift};
        rx_done <= 1'b1;
        rx_cnt  <= '0;
      end else if (abort) begin
        rx_cnt <= '0;
      end else if (rise) begin
        rx_shift <= {mosi_s, rx_shift[6:1]};
        rx_cnt   <= rx_cnt + 4'd1;
      end
    end
  end

  // Transmit path and double buffer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift    <= '0;
      tx_buf      <= '0;
      tx_cnt      <= '0;
      armed       <= 1'b0;
      tx_empty    <= 1'b1;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= underrun_hit;

      if (tx_load) tx_buf <= tx_data;

      if (tx_load)  tx_empty <= 1'b0;
      else if (arm) tx_empty <= 1'b1;

      if (underrun_hit) tx_shift <= 8'h00;
      else if (arm)     tx_shift <= tx_buf;
      else if (fall)    tx_shift <= {1'b0, tx_shift[7:1]};

      if (tx_last || abort)       armed <= 1'b0;
      else if (underrun_hit || arm) armed <= 1'b1;

      if (!active || tx_last || abort) tx_cnt <= '0;
      else if (fall)                   tx_cnt <= tx_cnt + 4'd1;
    end
  end

  // Mid-byte silence counter; restarts on any edge and saturates at the limit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                              timer <= '0;
    else if (!active || !mid_byte || rise || fall) timer <= '0;
    else if (timer != TW'(IDLE_TIMEOUT))       timer <= timer + 1'b1;
  end

  assign miso = active & tx_shift[0];
  assign busy = mid_byte;

endmodule
